// File: rtl/fixed_leaky_relu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// activation_arb_pkg
//
// Shared types and helpers for the leaky-ReLU arbiter slice.
//   arb_state_t : arbiter FSM states (idle search / locked to a packet owner)
//   rr_pick_t   : result of a round-robin search (found flag, index, one-hot)
//   rr_pick()   : round-robin search starting at a pointer, wrapping at
//                 num_req. Vectors are sized for up to RR_MAX_REQ requesters
//                 so one function serves every parameterisation; callers
//                 zero-extend their valid vector and take the low bits back.
// ---------------------------------------------------------------------------
package activation_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    localparam int RR_MAX_REQ = 32;
    localparam int RR_IDX_W   = 5;

    typedef struct packed {
        logic                  found;
        logic [RR_IDX_W-1:0]   idx;
        logic [RR_MAX_REQ-1:0] grant;
    } rr_pick_t;

    // Walk the candidates ptr, ptr+1, ... modulo num_req and keep the first
    // one whose valid bit is set. Since ptr < num_req and k < num_req, a
    // single conditional subtraction is enough to wrap.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDX_W-1:0]   ptr,
        input int                    num_req
    );
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = 0; k < RR_MAX_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((k < num_req) && (cand < num_req) && !res.found &&
                valid[cand[RR_IDX_W-1:0]]) begin
                res.found                     = 1'b1;
                res.idx                       = cand[RR_IDX_W-1:0];
                res.grant[cand[RR_IDX_W-1:0]] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/leaky_relu_lane.sv
// ---------------------------------------------------------------------------
// leaky_relu_lane
//
// One combinational leaky-ReLU element: non-negative inputs pass through,
// negative inputs are arithmetically shifted right by LEAK_SHIFT (slope
// 2^-LEAK_SHIFT, rounding toward minus infinity). Same width in and out;
// the shift can only shrink magnitude, so no saturation is needed.
//   x : signed two's complement input element
//   y : activated element
// ---------------------------------------------------------------------------
module leaky_relu_lane #(
    parameter int IN_WIDTH   = 8,
    parameter int LEAK_SHIFT = 3
) (
    input  logic [IN_WIDTH-1:0] x,
    output logic [IN_WIDTH-1:0] y
);

    // Keep the arithmetic shift in its own signed net so the surrounding
    // unsigned mux cannot turn it into a logical shift.
    logic signed [IN_WIDTH-1:0] x_signed;
    logic signed [IN_WIDTH-1:0] x_shifted;

    assign x_signed  = x;
    assign x_shifted = x_signed >>> LEAK_SHIFT;
    assign y         = x[IN_WIDTH-1] ? x_shifted : x;

endmodule

// File: rtl/fixed_leaky_relu_arbiter.sv
// ---------------------------------------------------------------------------
// fixed_leaky_relu_arbiter
//
// Shares one registered leaky-ReLU datapath between NUM_REQ vector streams.
// Packets are atomic: once a multi-beat packet starts, the grant stays with
// its owner until the beat flagged last is accepted. Between packets the
// grant rotates round-robin starting after the previous packet's owner.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_data        : [NUM_REQ][IN_SIZE][IN_WIDTH] requester vectors
//   req_valid       : per-requester beat valid
//   req_last        : per-requester last-beat-of-packet flag
//   req_ready       : per-requester ready (combinational from state + valid)
//   data_out        : activated vector (registered)
//   data_out_tag    : index of the requester that produced data_out
//   data_out_last   : last flag of the registered beat
//   data_out_valid  : output register holds a beat
//   data_out_ready  : downstream accepts the registered beat
// ---------------------------------------------------------------------------
module fixed_leaky_relu_arbiter
    import activation_arb_pkg::*;
#(
    parameter int IN_WIDTH   = 8,
    parameter int IN_SIZE    = 8,
    parameter int NUM_REQ    = 4,
    parameter int LEAK_SHIFT = 3,
    parameter int TAG_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0]                        req_last,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [IN_SIZE-1:0][IN_WIDTH-1:0]          data_out,
    output logic [TAG_WIDTH-1:0]                      data_out_tag,
    output logic                                      data_out_last,
    output logic                                      data_out_valid,
    input  logic                                      data_out_ready
);

    arb_state_t                       state;
    logic [TAG_WIDTH-1:0]             owner;
    logic [TAG_WIDTH-1:0]             rr_ptr;
    logic [TAG_WIDTH-1:0]             next_ptr;
    logic [TAG_WIDTH-1:0]             grant_idx;
    logic                             grant_valid;
    logic [NUM_REQ-1:0]               grant_onehot;
    logic                             out_free;
    logic                             accept;
    logic                             sel_last;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] sel_data;
    logic [IN_SIZE-1:0][IN_WIDTH-1:0] act_data;
    rr_pick_t                         pick;
    logic                             unused_pick;

    // Round-robin candidate for the idle state. The package helper works on
    // fixed-size vectors, so the valid bits and pointer are zero-extended
    // here and only the low bits of the result are used below.
    always_comb begin
        pick = rr_pick(RR_MAX_REQ'(req_valid), RR_IDX_W'(rr_ptr), NUM_REQ);
    end

    assign unused_pick = ^pick;

    // Grant selection. While locked the owner keeps the grant even when it
    // drops valid, which deliberately stalls everyone else so packets are
    // never interleaved. While idle the round-robin search decides.
    always_comb begin
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        if (state == ARB_LOCKED) begin
            grant_valid = 1'b1;
            grant_idx   = owner;
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_onehot[i] = (owner == TAG_WIDTH'(i));
            end
        end else begin
            grant_valid  = pick.found;
            grant_idx    = pick.idx[TAG_WIDTH-1:0];
            grant_onehot = pick.grant[NUM_REQ-1:0];
        end
    end

    // The output register can take a new beat when it is empty or is being
    // drained this cycle; that same-cycle drain-and-load gives full rate.
    assign out_free  = !data_out_valid || data_out_ready;
    assign req_ready = grant_onehot & {NUM_REQ{out_free && !rst}};
    assign accept    = grant_valid && req_valid[grant_idx] && out_free && !rst;

    assign sel_data  = req_data[grant_idx];
    assign sel_last  = req_last[grant_idx];
    assign next_ptr  = (grant_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0
                                                              : grant_idx + TAG_WIDTH'(1);

    // One activation lane per vector element, fed from the grant mux.
    for (genvar g = 0; g < IN_SIZE; g++) begin : g_lane
        leaky_relu_lane #(
            .IN_WIDTH   (IN_WIDTH),
            .LEAK_SHIFT (LEAK_SHIFT)
        ) u_lane (
            .x (sel_data[g]),
            .y (act_data[g])
        );
    end

    // Arbiter FSM, round-robin pointer and output register in one block.
    // A packet-ending accept returns to idle and moves the pointer just past
    // the owner; any other accept locks onto the granted requester. Reset
    // discards both the lock and whatever beat is sitting in the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ARB_IDLE;
            owner          <= '0;
            rr_ptr         <= '0;
            data_out       <= '0;
            data_out_tag   <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else begin
            if (accept) begin
                data_out       <= act_data;
                data_out_tag   <= grant_idx;
                data_out_last  <= sel_last;
                data_out_valid <= 1'b1;
                if (sel_last) begin
                    state  <= ARB_IDLE;
                    rr_ptr <= next_ptr;
                end else begin
                    state  <= ARB_LOCKED;
                    owner  <= grant_idx;
                end
            end else if (data_out_ready) begin
                data_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fixed_leaky_relu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fixed_leaky_relu_arbiter
//
// Self-checking bench for fixed_leaky_relu_arbiter. Each requester is a
// small source model draining its own beat queue; expected output beats are
// pushed to a scoreboard queue when stimulus is queued and popped when the
// DUT hands a beat downstream. A table of hand-computed vectors covers the
// element function; short hand-written sequences cover arbitration, packet
// locking, back-pressure and reset.
// ---------------------------------------------------------------------------
module tb_fixed_leaky_relu_arbiter;

    localparam int IN_WIDTH   = 8;
    localparam int IN_SIZE    = 8;
    localparam int NUM_REQ    = 4;
    localparam int LEAK_SHIFT = 3;
    localparam int TAG_WIDTH  = 2;

    typedef logic [IN_SIZE-1:0][IN_WIDTH-1:0] vec_t;

    typedef struct {
        vec_t data;
        logic last;
        bit   bubble;
    } beat_t;

    typedef struct {
        vec_t                 data;
        logic [TAG_WIDTH-1:0] tag;
        logic                 last;
    } exp_t;

    typedef struct {
        int   req;
        vec_t in_vec;
        vec_t out_vec;
    } table_t;

    logic                               clk;
    logic                               rst;
    logic [NUM_REQ-1:0][IN_SIZE-1:0][IN_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ-1:0]                 req_last;
    logic [NUM_REQ-1:0]                 req_ready;
    vec_t                               data_out;
    logic [TAG_WIDTH-1:0]               data_out_tag;
    logic                               data_out_last;
    logic                               data_out_valid;
    logic                               data_out_ready;

    beat_t              src_q [NUM_REQ][$];
    exp_t               sb_q[$];
    int                 xfer_cyc[$];
    bit [NUM_REQ-1:0]   fire;
    bit [NUM_REQ-1:0]   shown_bubble;
    int                 cyc;
    int                 checks;
    int                 errors;

    fixed_leaky_relu_arbiter #(
        .IN_WIDTH   (IN_WIDTH),
        .IN_SIZE    (IN_SIZE),
        .NUM_REQ    (NUM_REQ),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_data       (req_data),
        .req_valid      (req_valid),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .data_out       (data_out),
        .data_out_tag   (data_out_tag),
        .data_out_last  (data_out_last),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference element function written as floor division rather than a
    // shift: floor(v / 8) for negative v is -((-v + 7) / 8).
    function automatic vec_t leaky_vec(input vec_t v);
        vec_t                 r;
        logic signed [7:0]    e;
        int                   x;
        int                   y;
        r = '0;
        for (int i = 0; i < IN_SIZE; i++) begin
            e = v[i];
            x = int'(e);
            y = (x < 0) ? -((-x + (1 << LEAK_SHIFT) - 1) / (1 << LEAK_SHIFT)) : x;
            r[i] = y[7:0];
        end
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int i = 0; i < IN_SIZE; i++) begin
            r[i] = 8'($urandom_range(0, 255));
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Queue one beat on a requester, preceded by 'gap' cycles of valid low,
    // and optionally record the output beat it should produce.
    task automatic applyStimulus(input int req, input vec_t data, input logic last,
                                 input int gap, input bit expect_out);
        beat_t b;
        exp_t  e;
        for (int g = 0; g < gap; g++) begin
            b.data   = '0;
            b.last   = 1'b0;
            b.bubble = 1'b1;
            src_q[req].push_back(b);
        end
        b.data   = data;
        b.last   = last;
        b.bubble = 1'b0;
        src_q[req].push_back(b);
        if (expect_out) begin
            e.data = leaky_vec(data);
            e.tag  = TAG_WIDTH'(req);
            e.last = last;
            sb_q.push_back(e);
        end
    endtask

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            sync();
            done = (sb_q.size() == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (src_q[i].size() != 0) done = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s timeout: %0d beats still expected", name, sb_q.size());
        end
    endtask

    // Source models and output monitor. Inputs change on the falling edge;
    // handshakes are evaluated 2 time units later, after the main thread has
    // set data_out_ready/rst for this cycle, and take effect at the next
    // rising edge.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((fire[i] || shown_bubble[i]) && src_q[i].size() > 0) begin
                void'(src_q[i].pop_front());
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]    = !src_q[i][0].bubble;
                req_data[i]     = src_q[i][0].data;
                req_last[i]     = src_q[i][0].last;
                shown_bubble[i] = src_q[i][0].bubble;
            end else begin
                req_valid[i]    = 1'b0;
                req_data[i]     = '0;
                req_last[i]     = 1'b0;
                shown_bubble[i] = 1'b0;
            end
        end
        #2;
        fire = req_valid & req_ready;
        if (!rst && data_out_valid && data_out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_beat: got tag %0d data %h, expected nothing",
                         data_out_tag, data_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("out_data", data_out, e.data);
                checkOutput("out_tag", 64'(data_out_tag), 64'(e.tag));
                checkOutput("out_last", 64'(data_out_last), 64'(e.last));
                xfer_cyc.push_back(cyc);
            end
        end
    end

    table_t vectors[4];

    initial begin
        vec_t va, vb;
        int   n;

        vectors[0] = '{0, {8{8'hF0}}, {8{8'hFE}}};
        vectors[1] = '{1, {8'h7F, 8'h00, 8'h80, 8'hFF, 8'hF9, 8'hF0, 8'h01, 8'hC0},
                          {8'h7F, 8'h00, 8'hF0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 8'hF8}};
        vectors[2] = '{2, {8'h08, 8'hF8, 8'h40, 8'hBF, 8'h10, 8'hE0, 8'h81, 8'h7E},
                          {8'h08, 8'hFF, 8'h40, 8'hF7, 8'h10, 8'hFC, 8'hF0, 8'h7E}};
        vectors[3] = '{3, {8'hFE, 8'h02, 8'hF1, 8'h00, 8'h90, 8'h7F, 8'h88, 8'hF7},
                          {8'hFF, 8'h02, 8'hFE, 8'h00, 8'hF2, 8'h7F, 8'hF1, 8'hFE}};

        checks         = 0;
        errors         = 0;
        cyc            = 0;
        fire           = '0;
        shown_bubble   = '0;
        req_valid      = '0;
        req_data       = '0;
        req_last       = '0;
        rst            = 1'b1;
        data_out_ready = 1'b1;

        // Reset values, while in reset and just after release
        repeat (3) sync();
        #2;
        checkOutput("rst_valid", 64'(data_out_valid), 64'd0);
        checkOutput("rst_ready", 64'(req_ready), 64'd0);
        sync();
        rst = 1'b0;
        #2;
        checkOutput("rst_data", data_out, 64'd0);
        checkOutput("rst_tag", 64'(data_out_tag), 64'd0);
        checkOutput("rst_last", 64'(data_out_last), 64'd0);

        // Table-driven single-beat vectors through the element function
        for (int t = 0; t < 4; t++) begin
            beat_t b;
            exp_t  e;
            b.data   = vectors[t].in_vec;
            b.last   = 1'b1;
            b.bubble = 1'b0;
            src_q[vectors[t].req].push_back(b);
            e.data = vectors[t].out_vec;
            e.tag  = TAG_WIDTH'(vectors[t].req);
            e.last = 1'b1;
            sb_q.push_back(e);
            wait_idle(20, "table");
        end

        // All four requesters valid with single-beat packets: 0,1,2,3,0,1
        xfer_cyc.delete();
        applyStimulus(0, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(2, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(3, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(0, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b1, 0, 1'b1);
        wait_idle(40, "round_robin");
        if (xfer_cyc.size() == 6) checkOutput("rr_no_bubbles", 64'(xfer_cyc[5] - xfer_cyc[0]), 64'd5);

        // Move the pointer to requester 1
        applyStimulus(0, rand_vec(), 1'b1, 0, 1'b1);
        wait_idle(20, "ptr_setup");

        // 3-beat packet from requester 1 competing with 0 and 2: 1,1,1,2,0
        xfer_cyc.delete();
        applyStimulus(1, rand_vec(), 1'b0, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b0, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(2, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(0, rand_vec(), 1'b1, 0, 1'b1);
        wait_idle(40, "packet_lock");
        if (xfer_cyc.size() == 5) checkOutput("pkt_no_bubbles", 64'(xfer_cyc[4] - xfer_cyc[0]), 64'd4);

        // Same packet with requester 1 going idle for 2 cycles mid-packet
        xfer_cyc.delete();
        applyStimulus(1, rand_vec(), 1'b0, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b0, 2, 1'b1);
        applyStimulus(1, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(2, rand_vec(), 1'b1, 0, 1'b1);
        applyStimulus(0, rand_vec(), 1'b1, 0, 1'b1);
        wait_idle(40, "packet_gap");
        if (xfer_cyc.size() == 5) checkOutput("pkt_gap_bubble", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd3);

        // Back-pressure: requester 2 fills the register (pointer is at 1),
        // requester 0 waits behind it
        xfer_cyc.delete();
        data_out_ready = 1'b0;
        va = rand_vec();
        vb = rand_vec();
        applyStimulus(2, va, 1'b1, 0, 1'b1);
        applyStimulus(0, vb, 1'b1, 0, 1'b1);
        sync();
        for (int s = 0; s < 5; s++) begin
            sync();
            #2;
            checkOutput("stall_valid", 64'(data_out_valid), 64'd1);
            checkOutput("stall_data", data_out, leaky_vec(va));
            checkOutput("stall_tag", 64'(data_out_tag), 64'd2);
            checkOutput("stall_last", 64'(data_out_last), 64'd1);
            checkOutput("stall_ready", 64'(req_ready), 64'd0);
        end
        sync();
        data_out_ready = 1'b1;
        #2;
        checkOutput("release_ready", 64'(req_ready), 64'b0001);
        wait_idle(20, "stall");
        if (xfer_cyc.size() == 2) checkOutput("release_b2b", 64'(xfer_cyc[1] - xfer_cyc[0]), 64'd1);

        // Reset while the 2nd beat of a locked packet sits in the register
        applyStimulus(1, rand_vec(), 1'b0, 0, 1'b1);
        applyStimulus(1, rand_vec(), 1'b0, 0, 1'b0);
        applyStimulus(1, rand_vec(), 1'b1, 0, 1'b0);
        n = 0;
        while (src_q[1].size() != 1 && n < 20) begin
            sync();
            n++;
        end
        checkOutput("reset_setup", 64'(src_q[1].size()), 64'd1);
        rst = 1'b1;
        src_q[1].delete();
        #2;
        checkOutput("in_reset_ready", 64'(req_ready), 64'd0);
        sync();
        rst = 1'b0;
        #2;
        checkOutput("post_rst_valid", 64'(data_out_valid), 64'd0);
        checkOutput("post_rst_data", data_out, 64'd0);
        checkOutput("post_rst_tag", 64'(data_out_tag), 64'd0);
        checkOutput("post_rst_last", 64'(data_out_last), 64'd0);
        checkOutput("post_rst_ready", 64'(req_ready), 64'd0);
        applyStimulus(3, rand_vec(), 1'b1, 0, 1'b1);
        wait_idle(20, "after_reset");

        repeat (3) sync();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
